// File: rtl/sa_psum_collector.sv
// De-skews the systolic array's bottom-edge psums, accumulates rows across K tiles
// in a row-indexed bank, and queues finished rows for the post-processing stage.
module sa_psum_collector #(
  parameter int DATA_W_OUT = 32,
  parameter int ACC_W      = 32,
  parameter int N_SIZE     = 16,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_SIZE-1:0][DATA_W_OUT-1:0]   psum_in,
  input  logic                                valid_in,
  input  logic                                first_k,
  input  logic                                last_k,
  input  logic [$clog2(DEPTH+1)-1:0]          num_rows,
  output logic [N_SIZE-1:0][ACC_W-1:0]        out_row,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                overflow,
  output logic                                busy
);

  localparam int NR_W  = $clog2(DEPTH + 1);
  localparam int RP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TAG_N = N_SIZE - 1;

  typedef logic [N_SIZE-1:0][ACC_W-1:0] row_t;

  // Lane c waits N_SIZE-1-c cycles so every lane of a row lines up with the last lane.
  logic [N_SIZE-1:0][DATA_W_OUT-1:0] aligned;
  assign aligned[N_SIZE-1] = psum_in[N_SIZE-1];

  for (genvar c = 0; c < N_SIZE - 1; c++) begin : g_lane
    localparam int LEN = N_SIZE - 1 - c;
    logic [DATA_W_OUT-1:0] chain [LEN];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < LEN; s++) chain[s] <= '0;
      end else begin
        chain[0] <= psum_in[c];
        for (int s = 1; s < LEN; s++) chain[s] <= chain[s-1];
      end
    end
    assign aligned[c] = chain[LEN-1];
  end

  logic [TAG_N-1:0] tag_v, tag_f, tag_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      tag_f <= '0;
      tag_l <= '0;
    end else begin
      tag_v[0] <= valid_in;
      tag_f[0] <= first_k;
      tag_l[0] <= last_k;
      for (int s = 1; s < TAG_N; s++) begin
        tag_v[s] <= tag_v[s-1];
        tag_f[s] <= tag_f[s-1];
        tag_l[s] <= tag_l[s-1];
      end
    end
  end

  logic al_v, al_f, al_l;
  assign al_v = tag_v[TAG_N-1];
  assign al_f = tag_f[TAG_N-1];
  assign al_l = tag_l[TAG_N-1];

  // Accumulator bank and row pointer.
  row_t            acc [DEPTH];
  logic [RP_W-1:0] rp;
  logic [NR_W-1:0] eff_rows;
  logic            rp_last;
  row_t            new_row;

  assign eff_rows = (num_rows == '0 || num_rows > NR_W'(DEPTH)) ? NR_W'(DEPTH) : num_rows;
  assign rp_last  = (NR_W'(rp) >= eff_rows - NR_W'(1));

  always_comb begin
    new_row = '0;
    for (int c = 0; c < N_SIZE; c++) begin
      new_row[c] = (al_f ? '0 : acc[rp][c]) + ACC_W'($signed(aligned[c]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp <= '0;
      for (int d = 0; d < DEPTH; d++) acc[d] <= '0;
    end else if (al_v) begin
      acc[rp] <= new_row;
      rp      <= rp_last ? '0 : rp + RP_W'(1);
    end
  end

  // Output handshake: out_row is the FIFO head while out_valid=1 and is taken on any
  // rising edge where out_valid && out_ready; out_row is forced to zero while empty.
  row_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, full, do_push;

  assign push    = al_v & al_l;
  assign pop     = out_valid & out_ready;
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_push = push & (~full | pop);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= new_row;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && full && !pop) overflow <= 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign out_row   = out_valid ? mem[rd_ptr] : '0;
  assign busy      = (|tag_v) | out_valid;

endmodule
